// File: rtl/cordic_sum_sequencer.sv
// cordic_sum_sequencer: sequences a shared CORDIC unit and FP32 adder to form f(dataa) + datab.
// Optional wait-state timeout is enabled by defining CSEQ_TIMEOUT_EN.
module cordic_sum_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_timeout,
    output logic        cordic_start,
    output logic [31:0] cordic_data,
    input  logic [31:0] cordic_result,
    input  logic        cordic_done,
    output logic        adder_enable,
    output logic [31:0] adder_dataa,
    output logic [31:0] adder_datab,
    input  logic [31:0] adder_result,
    input  logic        adder_done
);
    typedef enum logic [2:0] {IDLE, C_REQ, C_WAIT, A_WAIT, FIN} state_t;
    state_t      state_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        busy_q;
    logic        err_overrun_q;
    logic        cordic_start_q;
    logic [31:0] cordic_data_q;
    logic        adder_enable_q;
    logic [31:0] adder_dataa_q;
    logic [31:0] adder_datab_q;
    if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_to_w_check
        $error("TO_W too narrow to hold TIMEOUT_CYCLES");
    end
`ifdef CSEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_timeout_q;
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif
    assign result       = result_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign err_overrun  = err_overrun_q;
    assign cordic_start = cordic_start_q;
    assign cordic_data  = cordic_data_q;
    assign adder_enable = adder_enable_q;
    assign adder_dataa  = adder_dataa_q;
    assign adder_datab  = adder_datab_q;
    // Request FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            result_q       <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            err_overrun_q  <= 1'b0;
            cordic_start_q <= 1'b0;
            cordic_data_q  <= '0;
            adder_enable_q <= 1'b0;
            adder_dataa_q  <= '0;
            adder_datab_q  <= '0;
`ifdef CSEQ_TIMEOUT_EN
            to_cnt_q       <= '0;
            err_timeout_q  <= 1'b0;
`endif
        end else begin
            cordic_start_q <= 1'b0;
            done_q         <= 1'b0;
            if (start && state_q != IDLE) err_overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cordic_data_q  <= dataa;
                        adder_datab_q  <= datab;
                        cordic_start_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= C_REQ;
                    end
                end
                C_REQ: begin
`ifdef CSEQ_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q <= C_WAIT;
                end
                C_WAIT: begin
                    if (cordic_done) begin
                        adder_dataa_q  <= cordic_result;
                        adder_enable_q <= 1'b1;
                        state_q        <= A_WAIT;
`ifdef CSEQ_TIMEOUT_EN
                        to_cnt_q       <= '0;
                    end else if (to_cnt_q == TO_LIMIT) begin
                        result_q       <= 32'h7FC0_0000;
                        err_timeout_q  <= 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= FIN;
                    end else begin
                        to_cnt_q       <= to_cnt_q + 1'b1;
`endif
                    end
                end
                A_WAIT: begin
                    if (adder_done) begin
                        result_q       <= adder_result;
                        adder_enable_q <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= FIN;
`ifdef CSEQ_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LIMIT) begin
                        result_q       <= 32'h7FC0_0000;
                        err_timeout_q  <= 1'b1;
                        adder_enable_q <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= FIN;
                    end else begin
                        to_cnt_q       <= to_cnt_q + 1'b1;
`endif
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sum_sequencer.sv
// tb_cordic_sum_sequencer: directed and randomized checks of request timing, latching and error flags.
module tb_cordic_sum_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err_overrun;
    logic        err_timeout;
    logic        cordic_start;
    logic [31:0] cordic_data;
    logic [31:0] cordic_result = '0;
    logic        cordic_done = 1'b0;
    logic        adder_enable;
    logic [31:0] adder_dataa;
    logic [31:0] adder_datab;
    logic [31:0] adder_result = '0;
    logic        adder_done = 1'b0;
    int          vectors = 0;
    int          errs = 0;
    logic        ovr_exp = 1'b0;
    logic [31:0] res_exp = '0;

    cordic_sum_sequencer #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
        .result(result), .done(done), .busy(busy), .err_overrun(err_overrun),
        .err_timeout(err_timeout), .cordic_start(cordic_start), .cordic_data(cordic_data),
        .cordic_result(cordic_result), .cordic_done(cordic_done), .adder_enable(adder_enable),
        .adder_dataa(adder_dataa), .adder_datab(adder_datab), .adder_result(adder_result),
        .adder_done(adder_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_result", result, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(err_overrun), 0);
        chk("rst_to", 32'(err_timeout), 0);
        chk("rst_cstart", 32'(cordic_start), 0);
        chk("rst_cdata", cordic_data, 0);
        chk("rst_aen", 32'(adder_enable), 0);
        chk("rst_adataa", adder_dataa, 0);
        chk("rst_adatab", adder_datab, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One request with CORDIC latency k, adder latency m; start issued in cycle 0.
    // ov: cycle of an extra start while busy (-1 none); rs: cycle reset is asserted (-1 none).
    task automatic run_req(input int k, input int m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] cr, input logic [31:0] ar, input int ov, input int rs,
                           input bit strays);
        int fin = 3 + k + m;
        int last = (rs >= 0) ? rs + 3 : fin;
        for (int t = 0; t <= last; t++) begin
            start         = (t == 0) || (t == ov);
            dataa         = (t == 0) ? a : $urandom;
            datab         = (t == 0) ? b : $urandom;
            cordic_done   = (t == 1 + k) || (strays && t == 2 + k);
            cordic_result = (t == 1 + k) ? cr : $urandom;
            adder_done    = (t == 2 + k + m) || (strays && t == 2) || (rs >= 0 && t == rs + 1);
            adder_result  = (t == 2 + k + m) ? ar : $urandom;
            reset         = (t == rs);
            @(negedge clk);
            if (rs >= 0 && t > rs) begin
                res_exp = '0;
                chk_zero();
            end else begin
                if (t == fin) res_exp = ar;
                chk("cordic_start", 32'(cordic_start), 32'(t == 1));
                chk("busy", 32'(busy), 32'(t >= 1 && t <= fin));
                chk("adder_enable", 32'(adder_enable), 32'(t >= 2 + k && t <= 2 + k + m));
                chk("done", 32'(done), 32'(t == fin));
                chk("result", result, res_exp);
                chk("err_overrun", 32'(err_overrun), 32'(ovr_exp));
                chk("err_timeout", 32'(err_timeout), 0);
                if (t >= 1) chk("cordic_data", cordic_data, a);
                if (t >= 1) chk("adder_datab", adder_datab, b);
                if (t >= 2 + k) chk("adder_dataa", adder_dataa, cr);
            end
            if (t == ov) ovr_exp = 1'b1;
            if (t == rs) ovr_exp = 1'b0;
            next_cycle();
        end
        start = 1'b0;
        cordic_done = 1'b0;
        adder_done = 1'b0;
        reset = 1'b0;
    endtask

`ifdef CSEQ_TIMEOUT_EN
    // Request whose CORDIC never answers (k < 0) or whose adder never answers.
    task automatic to_req(input int k);
        int fin = (k < 0) ? 11 : 11 + k;
        for (int t = 0; t <= fin; t++) begin
            start         = (t == 0);
            cordic_done   = (k >= 0) && (t == 1 + k);
            cordic_result = 32'h1234_5678;
            adder_done    = 1'b0;
            @(negedge clk);
            if (t == fin) res_exp = 32'h7FC0_0000;
            chk("to_busy", 32'(busy), 32'(t >= 1 && t <= fin));
            chk("to_done", 32'(done), 32'(t == fin));
            chk("to_result", result, res_exp);
            chk("to_aen", 32'(adder_enable), 32'(k >= 0 && t >= 2 + k && t < fin));
            chk("to_err", 32'(err_timeout), 32'(t == fin || (k >= 0)));
            next_cycle();
        end
        start = 1'b0;
        cordic_done = 1'b0;
    endtask
`endif

    initial begin
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_zero();
        next_cycle();
        run_req(3, 2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4020_0000, -1, -1, 1'b0);
        run_req(3, 2, 32'h3F80_0000, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, -1, -1, 1'b0);
        run_req(3, 2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4020_0000, 4, -1, 1'b0);
        run_req(3, 2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4020_0000, -1, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cordic_done = 1'b1;
            adder_done = (i[0] == 1'b1);
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_cstart", 32'(cordic_start), 0);
            chk("idle_aen", 32'(adder_enable), 0);
            next_cycle();
        end
        cordic_done = 1'b0;
        adder_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int k = int'($urandom_range(1, 6));
            int m = int'($urandom_range(1, 6));
            int ov = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 + k + m)) : -1;
            run_req(k, m, $urandom, $urandom, $urandom, $urandom, ov, -1, 1'($urandom_range(0, 1)));
        end
`ifdef CSEQ_TIMEOUT_EN
        to_req(-1);
        to_req(2);
`else
        start = 1'b1;
        dataa = $urandom;
        next_cycle();
        start = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            chk("hang_busy", 32'(busy), 1);
            chk("hang_done", 32'(done), 0);
            chk("hang_to", 32'(err_timeout), 0);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_zero();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
